data_mem_access_unit: RTL
=========================

DATA_MEM_ACCESS_UNIT -- requirements
Module: data_mem_access_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data and address width; SHALL be fixed at 32.
REQ-002 Parameter MEMORY_DEPTH, default 64, number of 32-bit words in the downstream single-port RAM.
REQ-003 Parameter BASE_ADDR, default 32'h1001_0000, byte address of RAM word 0.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  core access request.
REQ-007 req_ready  out  1  unit can accept a request.
REQ-008 req_write  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 req_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
REQ-011 req_addr  in  32  byte address.
REQ-012 req_wdata  in  32  store data, right-justified for sub-word stores.
REQ-013 resp_valid  out  1  one-cycle completion pulse.
REQ-014 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-015 resp_error  out  1  valid with resp_valid; request rejected.
REQ-016 mem_write_enable  out  1  to RAM write_enable.
REQ-017 mem_address  out  32  to RAM address, always word-aligned (bits 1:0 = 0).
REQ-018 mem_write_data  out  32  to RAM WriteData.
REQ-019 mem_read_data  in  32  from RAM ReadData, combinational, valid same cycle as mem_address.

Function
REQ-020 FSM states IDLE, ACCESS, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 IDLE: on req_valid=1 at a rising edge, latch write, size, unsigned, addr, wdata; go to RESP with error if error condition, else ACCESS.
REQ-022 Error condition: size 11; halfword with addr[0]=1; word with addr[1:0]!=0; addr < BASE_ADDR; addr >= BASE_ADDR + 4*MEMORY_DEPTH (32-bit compare, no wrap).
REQ-023 An erroring request SHALL never assert mem_write_enable.
REQ-024 mem_address SHALL equal latched addr with bits 1:0 cleared in ACCESS and WRITE, and hold its last value otherwise.
REQ-025 Byte lane k (addr[1:0]=k) SHALL be bits 8k+7:8k; halfword lane at addr[1] occupies bits 16*addr[1]+15:16*addr[1] (little-endian).
REQ-026 ACCESS, load: extract lane from mem_read_data, extend per unsigned, register into resp_rdata; go to RESP.
REQ-027 ACCESS, word store: mem_write_enable=1, mem_write_data=latched wdata for this cycle; go to RESP.
REQ-028 ACCESS, sub-word store: capture mem_read_data, merge low byte/halfword of wdata into addressed lane, leave other lanes unchanged; go to WRITE.
REQ-029 WRITE: mem_write_enable=1, mem_write_data=merged word for exactly one cycle; go to RESP.
REQ-030 RESP: resp_valid=1 for exactly one cycle, resp_error per REQ-022; go to IDLE.
REQ-031 Latency from accepting edge: error -> resp_valid next cycle; load or word store -> 2nd cycle; sub-word store -> 3rd cycle.
REQ-032 mem_write_enable SHALL be 0 in IDLE and RESP.
REQ-033 req_* inputs outside IDLE SHALL be ignored; no queuing.

Reset
REQ-034 reset=0 SHALL immediately force state IDLE, req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, mem_write_enable=0, mem_write_data=0, mem_address=BASE_ADDR.
REQ-035 Reset during ACCESS or WRITE SHALL abort the access with no RAM write and no response.

Verification
REQ-036 RAM word 0 = 0x8899_AABB; load byte signed at 0x1001_0002 -> resp_rdata 0xFFFF_FF99, resp_error 0, resp_valid 2 cycles after accept.
REQ-037 Same word; load halfword unsigned at 0x1001_0002 -> resp_rdata 0x0000_8899.
REQ-038 Store byte 0x55 at 0x1001_0001 onto 0x8899_AABB -> single write of 0x8899_55BB to address 0x1001_0000, resp_valid 3 cycles after accept.
REQ-039 Store word at 0x1001_0002 or at 0x1001_0100 (depth 64) -> resp_error 1 next cycle, mem_write_enable never asserted.
REQ-040 Word store 0xDEAD_BEEF to 0x1001_00FC, then load word there -> 0xDEAD_BEEF; req_ready 0 for all non-IDLE cycles.
REQ-041 Assert reset=0 during WRITE of a sub-word store -> RAM word unchanged, resp_valid 0, req_ready 1 while reset low.

Source files
------------

// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit: load/store front end for a single-port word RAM with sub-word read-modify-write.
module data_mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int MEMORY_DEPTH = 64,
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);
  localparam logic [32:0] LIMIT = 33'(BASE_ADDR) + 33'(4 * MEMORY_DEPTH);
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
  state_t state, next_state;
  logic        write_q, uns_q, err_q, req_err, word_st;
  logic [1:0]  size_q, off_q;
  logic [31:0] wdata_q, rdata_q, merged_q, addr_q;
  logic [31:0] load_data, mask, ins, merged;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  assign req_err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                   req_addr < BASE_ADDR || {1'b0, req_addr} >= LIMIT;
  // Little-endian lane selection from the word currently presented by the RAM
  assign lane_b = 8'(mem_read_data >> {off_q, 3'b000});
  assign lane_h = 16'(mem_read_data >> {off_q[1], 4'b0000});
  assign load_data = size_q == 2'b00 ? {{24{~uns_q & lane_b[7]}}, lane_b} :
                     size_q == 2'b01 ? {{16{~uns_q & lane_h[15]}}, lane_h} : mem_read_data;
  assign mask = size_q == 2'b00 ? 32'h0000_00FF << {off_q, 3'b000} : 32'h0000_FFFF << {off_q[1], 4'b0000};
  assign ins = size_q == 2'b00 ? {4{wdata_q[7:0]}} : {2{wdata_q[15:0]}};
  assign merged = (mem_read_data & ~mask) | (ins & mask);
  assign word_st = state == ACCESS && write_q && size_q == 2'b10;
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign resp_error = err_q & resp_valid;
  assign resp_rdata = rdata_q;
  assign mem_address = addr_q;
  assign mem_write_enable = word_st || state == WRITE;
  assign mem_write_data = word_st ? wdata_q : state == WRITE ? merged_q : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= next_state;
  end
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = req_valid ? (req_err ? RESP : ACCESS) : IDLE;
      ACCESS:  next_state = (write_q && size_q != 2'b10) ? WRITE : RESP;
      WRITE:   next_state = RESP;
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q  <= 1'b0;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      off_q    <= 2'b00;
      wdata_q  <= '0;
      rdata_q  <= '0;
      merged_q <= '0;
      addr_q   <= BASE_ADDR;
    end else if (state == IDLE && req_valid) begin
      write_q <= req_write;
      uns_q   <= req_unsigned;
      err_q   <= req_err;
      size_q  <= req_size;
      off_q   <= req_addr[1:0];
      wdata_q <= req_wdata;
      rdata_q <= '0;
      if (!req_err) addr_q <= {req_addr[31:2], 2'b00};
    end else if (state == ACCESS) begin
      if (!write_q) rdata_q <= load_data;
      merged_q <= merged;
    end
  end
endmodule
